feature_map_writer: RTL and testbench

FEATURE_MAP_WRITER -- requirements
Module: feature_map_writer

---
 rtl/feature_map_writer_pkg.sv | 24 ++
 rtl/feature_map_writer_sync_fifo.sv | 76 +++++++
 rtl/feature_map_writer.sv | 167 ++++++++++++++++
 tb/tb_feature_map_writer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/feature_map_writer_pkg.sv
// -----------------------------------------------------------------------------
// feature_map_writer_pkg
// Shared network parameters for the feature-map write-back path, and the
// state type of the writer's frame FSM.
//   NET_SUM_WIDTH     signed width of an adder-tree result
//   NET_OUT_WIDTH     signed width of a stored feature-map pixel
//   NET_SHIFT         right shift used to rescale a sum (>= 1)
//   NET_FRAME_PIXELS  output pixels per feature map
//   NET_FIFO_DEPTH    output buffer entries (power of two)
// -----------------------------------------------------------------------------
package feature_map_writer_pkg;

    localparam int NET_SUM_WIDTH    = 20;
    localparam int NET_OUT_WIDTH    = 8;
    localparam int NET_SHIFT        = 4;
    localparam int NET_FRAME_PIXELS = 16;
    localparam int NET_FIFO_DEPTH   = 4;

    typedef enum logic {
        FSM_IDLE = 1'b0,
        FSM_RUN  = 1'b1
    } fsm_state_t;

endpackage

// File: rtl/feature_map_writer_sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock first-word-fall-through FIFO used as the writer's output buffer.
//   clock  in   rising-edge clock
//   reset  in   synchronous active-low reset, empties the FIFO
//   push   in   write din this cycle (ignored when full unless pop is also high)
//   pop    in   remove the head entry this cycle (ignored when empty)
//   din    in   entry to write
//   dout   out  head entry, valid while empty = 0
//   full   out  DEPTH entries held
//   empty  out  no entries held
// Push and pop together on a full FIFO keep the occupancy at DEPTH. Whenever
// the last entry leaves, both pointers return to 0 so an idle FIFO always
// restarts from slot 0.
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] inc_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A full FIFO can still take a push when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_pop && !do_push && count == CNT_W'(1)) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (do_push) wr_ptr <= inc_ptr(wr_ptr);
                if (do_pop)  rd_ptr <= inc_ptr(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/feature_map_writer.sv
// -----------------------------------------------------------------------------
// feature_map_writer
// Takes one signed adder-tree sum per pixel_rdy cycle, rescales it with a
// round-half-up arithmetic shift, saturates it to OUT_WIDTH, optionally
// applies ReLU, and writes it to feature-map memory at sequential addresses.
//   clock         in   rising-edge clock
//   reset         in   synchronous active-low reset
//   pixel_rdy     in   pixel_in carries a sum this cycle (cannot be stalled)
//   pixel_in      in   signed SUM_WIDTH sum
//   relu_en       in   clamp negative results to 0 (sampled with pixel_in)
//   wr_valid      out  wr_addr / wr_data hold a write
//   wr_ready      in   memory accepts the write this cycle
//   wr_addr       out  linear pixel address, 0 .. FRAME_PIXELS-1
//   wr_data       out  rescaled pixel
//   frame_done    out  high with the write to address FRAME_PIXELS-1
//   overflow_err  out  sticky: a pixel was dropped because the buffer was full
//   fsm_state     out  frame FSM state (IDLE / RUN) for observation
//
// Handshake: a write transfers in any cycle where wr_valid and wr_ready are
// both high. Once wr_valid rises it stays high, and wr_addr / wr_data stay
// unchanged, until that transfer happens; wr_valid never depends on wr_ready.
//
// Pipeline: sample registered at the end of cycle N, rescaled during N+1 and
// pushed into the FIFO at the end of N+1, so the earliest write is in N+2.
// -----------------------------------------------------------------------------
module feature_map_writer
    import feature_map_writer_pkg::*;
#(
    parameter int SUM_WIDTH    = NET_SUM_WIDTH,
    parameter int OUT_WIDTH    = NET_OUT_WIDTH,
    parameter int SHIFT        = NET_SHIFT,
    parameter int FRAME_PIXELS = NET_FRAME_PIXELS,
    parameter int FIFO_DEPTH   = NET_FIFO_DEPTH,
    parameter int ADDR_W       = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 pixel_rdy,
    input  logic [SUM_WIDTH-1:0] pixel_in,
    input  logic                 relu_en,
    output logic                 wr_valid,
    input  logic                 wr_ready,
    output logic [ADDR_W-1:0]    wr_addr,
    output logic [OUT_WIDTH-1:0] wr_data,
    output logic                 frame_done,
    output logic                 overflow_err,
    output fsm_state_t           fsm_state
);

    // One guard bit so adding the rounding bias can never wrap.
    localparam int EXT_W = SUM_WIDTH + 1;
    localparam logic signed [EXT_W-1:0] ROUND_BIAS = EXT_W'(1 << (SHIFT - 1));
    localparam logic signed [EXT_W-1:0] OUT_MAX    = EXT_W'((1 << (OUT_WIDTH - 1)) - 1);
    localparam logic signed [EXT_W-1:0] OUT_MIN    = ~OUT_MAX;
    localparam logic [ADDR_W-1:0]       LAST_ADDR  = ADDR_W'(FRAME_PIXELS - 1);

    // Stage 1: registered sample
    logic                        s1_valid;
    logic signed [SUM_WIDTH-1:0] s1_sum;
    logic                        s1_relu;

    // Stage 1: rescale / saturate / ReLU
    logic signed [EXT_W-1:0]     sum_ext;
    logic signed [EXT_W-1:0]     rounded;
    logic signed [EXT_W-1:0]     shifted;
    logic        [OUT_WIDTH-1:0] saturated;
    logic        [OUT_WIDTH-1:0] s1_pixel;

    // Output buffer
    logic                        fifo_push;
    logic                        fifo_pop;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic        [OUT_WIDTH-1:0] fifo_dout;

    fsm_state_t                  state;

    always_ff @(posedge clock) begin
        if (!reset) begin
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= pixel_rdy;
        end
    end

    always_ff @(posedge clock) begin
        s1_sum  <= pixel_in;
        s1_relu <= relu_en;
    end

    always_comb begin
        sum_ext = {s1_sum[SUM_WIDTH-1], s1_sum};
        rounded = sum_ext + ROUND_BIAS;
        shifted = rounded >>> SHIFT;
        if (shifted > OUT_MAX) begin
            saturated = OUT_MAX[OUT_WIDTH-1:0];
        end else if (shifted < OUT_MIN) begin
            saturated = OUT_MIN[OUT_WIDTH-1:0];
        end else begin
            saturated = shifted[OUT_WIDTH-1:0];
        end
        if (s1_relu && saturated[OUT_WIDTH-1]) begin
            s1_pixel = '0;
        end else begin
            s1_pixel = saturated;
        end
    end

    assign fifo_pop  = wr_valid && wr_ready;
    assign fifo_push = s1_valid && (!fifo_full || fifo_pop);

    sync_fifo #(
        .WIDTH (OUT_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (s1_pixel),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign wr_valid   = !fifo_empty;
    assign wr_data    = fifo_dout;
    assign frame_done = fifo_pop && (wr_addr == LAST_ADDR);
    assign fsm_state  = state;

    // The input stream cannot stall, so a sample that finds the buffer full
    // with no write leaving is lost; remember that until reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            overflow_err <= 1'b0;
        end else if (s1_valid && fifo_full && !fifo_pop) begin
            overflow_err <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_addr <= '0;
        end else if (fifo_pop) begin
            wr_addr <= (wr_addr == LAST_ADDR) ? '0 : wr_addr + 1'b1;
        end
    end

    // Frame FSM. A push in the frame-ending cycle keeps it in RUN; entries
    // still buffered after a frame ends pull it straight back out of IDLE.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= FSM_IDLE;
        end else begin
            case (state)
                FSM_IDLE: begin
                    if (fifo_push || !fifo_empty) state <= FSM_RUN;
                end
                FSM_RUN: begin
                    if (frame_done && !fifo_push) state <= FSM_IDLE;
                end
                default: state <= FSM_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_feature_map_writer.sv
module tb_feature_map_writer;
    import feature_map_writer_pkg::*;

    // ---------------- clock / reset / DUT ----------------
    logic             clock;
    logic             reset;
    logic             pixel_rdy;
    logic [19:0]      pixel_in;
    logic             relu_en;
    logic             wr_valid;
    logic             wr_ready;
    logic [3:0]       wr_addr;
    logic [7:0]       wr_data;
    logic             frame_done;
    logic             overflow_err;
    fsm_state_t       fsm_state;

    feature_map_writer dut (
        .clock        (clock),
        .reset        (reset),
        .pixel_rdy    (pixel_rdy),
        .pixel_in     (pixel_in),
        .relu_en      (relu_en),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .frame_done   (frame_done),
        .overflow_err (overflow_err),
        .fsm_state    (fsm_state)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    // entry = {frame_done, addr[3:0], data[7:0]}
    logic [12:0] exp_q[$];
    int          checks   = 0;
    int          errors   = 0;
    int          n_writes = 0;
    int          exp_addr = 0;
    logic        hold_pending = 1'b0;
    logic [11:0] held;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge clock) begin
        logic [12:0] e;
        if (hold_pending && wr_valid) check("hold_stable", {20'd0, wr_addr, wr_data}, {20'd0, held});
        if (wr_valid && wr_ready) begin
            n_writes++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr=%0d data=0x%0h, expected no write", wr_addr, wr_data);
            end else begin
                e = exp_q.pop_front();
                check("wr_data",    {24'd0, wr_data},   {24'd0, e[7:0]});
                check("wr_addr",    {28'd0, wr_addr},   {28'd0, e[11:8]});
                check("frame_done", {31'd0, frame_done}, {31'd0, e[12]});
            end
        end else begin
            check("frame_done_no_xfer", {31'd0, frame_done}, 32'd0);
        end
        hold_pending = wr_valid && !wr_ready;
        held         = {wr_addr, wr_data};
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        pixel_rdy = 1'b0;
        wr_ready  = 1'b0;
        tick();
        tick();
        exp_q.delete();
        exp_addr  = 0;
        reset     = 1'b1;
        tick();
    endtask

    // Drive one sample for one cycle; queue the hand-computed result if kept.
    task automatic send(input int value, input logic relu, input logic [7:0] exp_data, input bit kept);
        pixel_rdy = 1'b1;
        pixel_in  = 20'(value);
        relu_en   = relu;
        if (kept) begin
            exp_q.push_back({(exp_addr == 15), 4'(exp_addr), exp_data});
            exp_addr = (exp_addr + 1) % 16;
        end
        tick();
        pixel_rdy = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
        check({"drain_", name}, exp_q.size(), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int base;
        reset     = 1'b0;
        pixel_rdy = 1'b1;
        pixel_in  = 20'd291;
        relu_en   = 1'b0;
        wr_ready  = 1'b1;

        // Reset state; the pixel_rdy held during reset must be ignored.
        tick(); tick(); tick();
        reset     = 1'b1;
        pixel_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("reset_wr_valid", {31'd0, wr_valid}, 32'd0);
            tick();
        end
        check("reset_overflow", {31'd0, overflow_err}, 32'd0);
        check("reset_wr_addr",  {28'd0, wr_addr},      32'd0);
        check("reset_fsm",      {31'd0, fsm_state},    {31'd0, FSM_IDLE});

        // Rounding and two-cycle latency: 291 -> 0x12 at address 0.
        do_reset();
        wr_ready = 1'b1;
        send(291, 1'b0, 8'h12, 1'b1);
        check("latency_n1_valid", {31'd0, wr_valid}, 32'd0);
        tick();
        check("latency_n2_valid", {31'd0, wr_valid}, 32'd1);
        check("latency_n2_data",  {24'd0, wr_data},  32'h12);
        wait_drain("rounding");

        // Saturation and ReLU.
        send(4095, 1'b0, 8'h7F, 1'b1);
        send(-100, 1'b0, 8'hFA, 1'b1);
        send(-100, 1'b1, 8'h00, 1'b1);
        wait_drain("sat_relu");

        // Backpressure: 5 samples into a 4-entry buffer with no writes.
        do_reset();
        base = n_writes;
        for (int i = 0; i < 5; i++) send(16 * (i + 1), 1'b0, 8'(i + 1), (i < 4));
        tick(); tick();
        check("bp_overflow", {31'd0, overflow_err}, 32'd1);
        check("bp_wr_addr",  {28'd0, wr_addr},      32'd0);
        check("bp_wr_valid", {31'd0, wr_valid},     32'd1);
        check("bp_head",     {24'd0, wr_data},      32'd1);
        wr_ready = 1'b1;
        wait_drain("backpressure");
        tick(); tick(); tick();
        check("bp_write_count", n_writes - base, 32'd4);
        check("bp_empty",       {31'd0, wr_valid}, 32'd0);

        // Full frame: 16 samples, addresses 0..15, frame_done only at 15.
        do_reset();
        wr_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            send(16 * i, 1'b0, 8'(i), 1'b1);
            if (i == 8) check("frame_fsm_run", {31'd0, fsm_state}, {31'd0, FSM_RUN});
        end
        wait_drain("frame");
        tick(); tick();
        check("frame_fsm_idle", {31'd0, fsm_state}, {31'd0, FSM_IDLE});
        check("frame_addr_wrap", {28'd0, wr_addr}, 32'd0);
        send(100, 1'b0, 8'h06, 1'b1);
        wait_drain("after_frame");

        // Full buffer with push and pop in the same cycle: nothing dropped.
        do_reset();
        base = n_writes;
        for (int i = 0; i < 6; i++) begin
            if (i == 5) wr_ready = 1'b1;
            send(16 * (i + 1), 1'b0, 8'(i + 1), 1'b1);
        end
        wait_drain("simultaneous");
        tick(); tick();
        check("simul_overflow",    {31'd0, overflow_err}, 32'd0);
        check("simul_write_count", n_writes - base, 32'd6);

        // Reset in the middle of a frame after 7 writes.
        do_reset();
        wr_ready = 1'b1;
        base = n_writes;
        for (int i = 0; i < 9; i++) send(16 * (i + 1), 1'b0, 8'(i + 1), 1'b1);
        for (int i = 0; i < 20 && (n_writes - base) < 7; i++) tick();
        check("midreset_writes", n_writes - base, 32'd7);
        reset    = 1'b0;
        wr_ready = 1'b0;
        exp_q.delete();
        exp_addr = 0;
        tick();
        check("midreset_wr_valid", {31'd0, wr_valid}, 32'd0);
        check("midreset_wr_addr",  {28'd0, wr_addr},  32'd0);
        reset    = 1'b1;
        wr_ready = 1'b1;
        send(32, 1'b0, 8'h02, 1'b1);
        wait_drain("midreset");

        tick(); tick();
        check("final_queue_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
